// File: rtl/alarm_sequencer_pkg.sv
// Shared definitions for the alarm sequencer: state codes, BCD limits and
// the two-digit BCD payload type. State codes and limits match the values
// used by binary_clock and pixel_clk_gen (IDLE=0, SET=1, ARMED=2,
// RINGING=3, SNOOZE=4; hour limit 23, minute limit 59).
package alarm_sequencer_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned DIGIT_W = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SET     = 3'd1;
  localparam logic [2:0] ST_ARMED   = 3'd2;
  localparam logic [2:0] ST_RINGING = 3'd3;
  localparam logic [2:0] ST_SNOOZE  = 3'd4;

  // Two BCD digits: tens in the upper nibble, ones in the lower nibble
  typedef struct packed {
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } bcd2_t;

  localparam bcd2_t MAX_HOUR = bcd2_t'(8'h23);
  localparam bcd2_t MAX_MIN  = bcd2_t'(8'h59);

  // True for every state in which the alarm counts as armed
  function automatic logic is_armed_state(input logic [STATE_W-1:0] s);
    return (s == ST_ARMED) || (s == ST_RINGING) || (s == ST_SNOOZE);
  endfunction

endpackage

// File: rtl/alarm_sequencer_bcd_wrap_inc.sv
// bcd_wrap_inc: combinational two-digit BCD increment that wraps to 00
// after LIMIT.
//   value  in   2-digit BCD operand (assumed within 00..LIMIT)
//   inc_c  out  value + 1, or 00 when value equals LIMIT
module bcd_wrap_inc
  import alarm_sequencer_pkg::*;
#(
  parameter bcd2_t LIMIT = MAX_MIN
) (
  input  bcd2_t value,
  output bcd2_t inc_c
);

  // Wrap takes precedence; otherwise carry from ones into tens at 9
  always_comb begin
    inc_c = value;
    if (value == LIMIT) begin
      inc_c = '0;
    end else if (value.ones == 4'd9) begin
      inc_c.tens = value.tens + 4'd1;
      inc_c.ones = 4'd0;
    end else begin
      inc_c.ones = value.ones + 4'd1;
    end
  end

endmodule

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: alarm control FSM. Holds the alarm time in BCD, compares
// it with the running time and sequences set / arm / ring / snooze.
// Optional feature macro: ALARM_SNOOZE_EN (adds the SNOOZE state and its
// counter; when undefined snooze_btn is ignored and code 4 is illegal).
// Ports:
//   clk_100MHz, reset         clock, synchronous active-high reset
//   tick_1hz                  one-cycle pulse per second
//   set_mode                  level, 1 = edit alarm time
//   arm_btn, snooze_btn       one-cycle button pulses
//   min_btn, hour_btn         one-cycle alarm edit pulses
//   cur_*                     running time, BCD digits
//   al_*                      alarm time, BCD digits
//   state_o, armed, ringing   FSM status
//   beep                      toggles per second while ringing
module alarm_sequencer
  import alarm_sequencer_pkg::*;
#(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300
) (
  input  logic               clk_100MHz,
  input  logic               reset,
  input  logic               tick_1hz,
  input  logic               set_mode,
  input  logic               arm_btn,
  input  logic               snooze_btn,
  input  logic               min_btn,
  input  logic               hour_btn,
  input  logic [3:0]         cur_hour_first,
  input  logic [3:0]         cur_hour_second,
  input  logic [3:0]         cur_min_first,
  input  logic [3:0]         cur_min_second,
  input  logic [3:0]         cur_sec_first,
  input  logic [3:0]         cur_sec_second,
  output logic [3:0]         al_hour_first,
  output logic [3:0]         al_hour_second,
  output logic [3:0]         al_min_first,
  output logic [3:0]         al_min_second,
  output logic [STATE_W-1:0] state_o,
  output logic               armed,
  output logic               ringing,
  output logic               beep
);

  localparam int unsigned RING_W = $clog2(RING_SECS + 1);

  logic [STATE_W-1:0] state, state_nxt;
  logic [RING_W-1:0]  ring_cnt, ring_nxt, ring_inc;
  bcd2_t              al_hour, al_hour_nxt, hour_inc_c;
  bcd2_t              al_min, al_min_nxt, min_inc_c;
  logic               match, match_q, trigger;
  logic               ring_timeout;
  logic               beep_nxt;

`ifdef ALARM_SNOOZE_EN
  localparam int unsigned SNZ_W = $clog2(SNOOZE_SECS + 1);
  logic [SNZ_W-1:0] snz_cnt, snz_nxt, snz_inc;
  logic             snz_timeout;
  assign snz_inc     = snz_cnt + SNZ_W'(tick_1hz);
  assign snz_timeout = (snz_inc == SNZ_W'(SNOOZE_SECS));
`else
  logic unused_snooze;
  assign unused_snooze = snooze_btn ^ SNOOZE_SECS[0];
`endif

  // Alarm digit incrementers; minute wrap never carries into the hour
  bcd_wrap_inc #(.LIMIT(MAX_MIN)) u_min_inc (
    .value (al_min),
    .inc_c (min_inc_c)
  );

  bcd_wrap_inc #(.LIMIT(MAX_HOUR)) u_hour_inc (
    .value (al_hour),
    .inc_c (hour_inc_c)
  );

  // Edge-detected match so a held matching second rings at most once
  assign match = ({cur_hour_first, cur_hour_second} == al_hour) &&
                 ({cur_min_first, cur_min_second} == al_min) &&
                 (cur_sec_first == 4'd0) && (cur_sec_second == 4'd0);
  assign trigger = match & ~match_q;

  // The tick that completes the ring period also causes the exit
  assign ring_inc     = ring_cnt + RING_W'(tick_1hz);
  assign ring_timeout = (ring_inc == RING_W'(RING_SECS));

  // Next-state, counter and alarm-register logic
  always_comb begin
    state_nxt   = state;
    ring_nxt    = ring_cnt;
    al_hour_nxt = al_hour;
    al_min_nxt  = al_min;
    beep_nxt    = 1'b0;
`ifdef ALARM_SNOOZE_EN
    snz_nxt     = snz_cnt;
`endif
    case (state)
      ST_IDLE: begin
        if (set_mode) begin
          state_nxt = ST_SET;
        end else if (arm_btn) begin
          state_nxt = ST_ARMED;
        end
      end
      ST_SET: begin
        if (min_btn) begin
          al_min_nxt = min_inc_c;
        end
        if (hour_btn) begin
          al_hour_nxt = hour_inc_c;
        end
        if (!set_mode) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (set_mode) begin
          state_nxt = ST_SET;
        end else if (arm_btn) begin
          state_nxt = ST_IDLE;
        end else if (trigger) begin
          state_nxt = ST_RINGING;
          ring_nxt  = '0;
        end
      end
      ST_RINGING: begin
        ring_nxt = ring_inc;
        beep_nxt = tick_1hz ? ~beep : beep;
        if (arm_btn) begin
          state_nxt = ST_ARMED;
          beep_nxt  = 1'b0;
`ifdef ALARM_SNOOZE_EN
        end else if (snooze_btn) begin
          state_nxt = ST_SNOOZE;
          snz_nxt   = '0;
          beep_nxt  = 1'b0;
`endif
        end else if (ring_timeout) begin
          state_nxt = ST_ARMED;
          beep_nxt  = 1'b0;
        end
      end
`ifdef ALARM_SNOOZE_EN
      ST_SNOOZE: begin
        snz_nxt = snz_inc;
        if (arm_btn) begin
          state_nxt = ST_ARMED;
        end else if (snz_timeout) begin
          state_nxt = ST_RINGING;
          ring_nxt  = '0;
        end
      end
`endif
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state    <= ST_IDLE;
      ring_cnt <= '0;
      match_q  <= 1'b0;
      al_hour  <= '0;
      al_min   <= '0;
      armed    <= 1'b0;
      ringing  <= 1'b0;
      beep     <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt  <= '0;
`endif
    end else begin
      state    <= state_nxt;
      ring_cnt <= ring_nxt;
      match_q  <= match;
      al_hour  <= al_hour_nxt;
      al_min   <= al_min_nxt;
      armed    <= is_armed_state(state_nxt);
      ringing  <= (state_nxt == ST_RINGING);
      beep     <= beep_nxt;
`ifdef ALARM_SNOOZE_EN
      snz_cnt  <= snz_nxt;
`endif
    end
  end

  assign state_o        = state;
  assign al_hour_first  = al_hour.tens;
  assign al_hour_second = al_hour.ones;
  assign al_min_first   = al_min.tens;
  assign al_min_second  = al_min.ones;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Self-checking bench for alarm_sequencer: table-driven alarm editing
// followed by directed sequences for ringing, snooze and reset.
module tb_alarm_sequencer;

  logic        clk_100MHz = 1'b0;
  logic        reset, tick_1hz, set_mode, arm_btn, snooze_btn, min_btn, hour_btn;
  logic [23:0] cur;
  logic [3:0]  al_hour_first, al_hour_second, al_min_first, al_min_second;
  logic [2:0]  state_o;
  logic        armed, ringing, beep;

  int tests = 0;
  int fails = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  alarm_sequencer #(.RING_SECS(60), .SNOOZE_SECS(3)) dut (
    .clk_100MHz      (clk_100MHz),
    .reset           (reset),
    .tick_1hz        (tick_1hz),
    .set_mode        (set_mode),
    .arm_btn         (arm_btn),
    .snooze_btn      (snooze_btn),
    .min_btn         (min_btn),
    .hour_btn        (hour_btn),
    .cur_hour_first  (cur[23:20]),
    .cur_hour_second (cur[19:16]),
    .cur_min_first   (cur[15:12]),
    .cur_min_second  (cur[11:8]),
    .cur_sec_first   (cur[7:4]),
    .cur_sec_second  (cur[3:0]),
    .al_hour_first   (al_hour_first),
    .al_hour_second  (al_hour_second),
    .al_min_first    (al_min_first),
    .al_min_second   (al_min_second),
    .state_o         (state_o),
    .armed           (armed),
    .ringing         (ringing),
    .beep            (beep)
  );

  typedef struct {
    logic        sm, arm, mn, hr;
    logic [2:0]  st;
    logic [15:0] al;
    logic        a, r, b;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic sm, logic arm, logic mn, logic hr,
                              logic [2:0] st, logic [15:0] al,
                              logic a, logic r, logic b);
    vec_t v;
    v.sm = sm; v.arm = arm; v.mn = mn; v.hr = hr;
    v.st = st; v.al = al; v.a = a; v.r = r; v.b = b;
    return v;
  endfunction

  task automatic step();
    @(posedge clk_100MHz);
    #1;
  endtask

  // Compare {state, alarm hh:mm, armed, ringing, beep}
  task automatic chk(input string name, input logic [2:0] st, input logic [15:0] al,
                     input logic a, input logic r, input logic b);
    logic [21:0] act, exp;
    act = {state_o, al_hour_first, al_hour_second, al_min_first, al_min_second,
           armed, ringing, beep};
    exp = {st, al, a, r, b};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got st=%0d al=%h a/r/b=%b, expected st=%0d al=%h a/r/b=%b",
               name, act[21:19], act[18:3], act[2:0], exp[21:19], exp[18:3], exp[2:0]);
    end
  endtask

  task automatic pulse(input logic arm, input logic snz, input logic mn,
                       input logic hr, input logic tk);
    arm_btn = arm; snooze_btn = snz; min_btn = mn; hour_btn = hr; tick_1hz = tk;
    step();
    arm_btn = 1'b0; snooze_btn = 1'b0; min_btn = 1'b0; hour_btn = 1'b0; tick_1hz = 1'b0;
  endtask

  task automatic tick();
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
  endtask

  // Rising-edge match from a non-matching second into 06:30:00
  task automatic start_ring();
    cur = 24'h063100;
    step();
    cur = 24'h063000;
    step();
  endtask

  initial begin
    reset = 1'b1; tick_1hz = 1'b0; set_mode = 1'b0; arm_btn = 1'b0;
    snooze_btn = 1'b0; min_btn = 1'b0; hour_btn = 1'b0; cur = 24'h120000;

    vecs[0]  = mk(1, 0, 0, 0, 3'd1, 16'h0000, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 1, 3'd1, 16'h0100, 0, 0, 0);
    vecs[2]  = mk(1, 0, 0, 1, 3'd1, 16'h0200, 0, 0, 0);
    vecs[3]  = mk(1, 0, 0, 1, 3'd1, 16'h0300, 0, 0, 0);
    vecs[4]  = mk(1, 0, 1, 0, 3'd1, 16'h0301, 0, 0, 0);
    vecs[5]  = mk(1, 0, 1, 0, 3'd1, 16'h0302, 0, 0, 0);
    vecs[6]  = mk(1, 0, 1, 0, 3'd1, 16'h0303, 0, 0, 0);
    vecs[7]  = mk(1, 0, 1, 0, 3'd1, 16'h0304, 0, 0, 0);
    vecs[8]  = mk(1, 0, 1, 0, 3'd1, 16'h0305, 0, 0, 0);
    vecs[9]  = mk(1, 0, 1, 0, 3'd1, 16'h0306, 0, 0, 0);
    vecs[10] = mk(1, 1, 1, 0, 3'd1, 16'h0307, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 3'd0, 16'h0307, 0, 0, 0);

    step(); step();
    chk("reset", 3'd0, 16'h0000, 0, 0, 0);
    reset = 1'b0;
    step();
    chk("idle_after_reset", 3'd0, 16'h0000, 0, 0, 0);

    // Alarm editing table (arm_btn inside SET is ignored)
    for (int i = 0; i < 12; i++) begin
      set_mode = vecs[i].sm;
      pulse(vecs[i].arm, 1'b0, vecs[i].mn, vecs[i].hr, 1'b0);
      chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].al, vecs[i].a, vecs[i].r, vecs[i].b);
    end

    // Buttons ignored outside SET
    pulse(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("idle_btn_ignored", 3'd0, 16'h0307, 0, 0, 0);

    // Walk to 23:59 using simultaneous and single presses
    set_mode = 1'b1;
    step();
    for (int i = 0; i < 20; i++) pulse(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("both_btn", 3'd1, 16'h2327, 0, 0, 0);
    for (int i = 0; i < 32; i++) pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("at_2359", 3'd1, 16'h2359, 0, 0, 0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("hour_wrap", 3'd1, 16'h0059, 0, 0, 0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("min_wrap_no_carry", 3'd1, 16'h0000, 0, 0, 0);

    // Alarm 06:30, leave SET, arm
    for (int i = 0; i < 6; i++) pulse(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 24; i++) pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    set_mode = 1'b0;
    step();
    chk("alarm_0630", 3'd0, 16'h0630, 0, 0, 0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("armed", 3'd2, 16'h0630, 1, 0, 0);

    // Ring on the 06:29:59 -> 06:30:00 edge
    cur = 24'h062959;
    step();
    chk("no_ring_0629", 3'd2, 16'h0630, 1, 0, 0);
    cur = 24'h063000;
    step();
    chk("ring_start", 3'd3, 16'h0630, 1, 1, 0);
    set_mode = 1'b1;
    step();
    chk("set_ignored_ringing", 3'd3, 16'h0630, 1, 1, 0);
    set_mode = 1'b0;
    for (int k = 1; k < 60; k++) begin
      tick();
      if (k <= 3 || k == 59)
        chk($sformatf("beep_tick%0d", k), 3'd3, 16'h0630, 1, 1, 1'(k % 2));
    end
    tick();
    chk("ring_timeout", 3'd2, 16'h0630, 1, 0, 0);
    repeat (3) step();
    chk("no_retrigger_held", 3'd2, 16'h0630, 1, 0, 0);

    // Arming during a matching second never rings
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("disarm", 3'd0, 16'h0630, 0, 0, 0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    chk("arm_in_match", 3'd2, 16'h0630, 1, 0, 0);

    // Dismiss beats snooze when pressed together
    start_ring();
    chk("ring2_start", 3'd3, 16'h0630, 1, 1, 0);
    tick();
    pulse(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("arm_over_snooze", 3'd2, 16'h0630, 1, 0, 0);

    // ARMED -> SET disarms
    set_mode = 1'b1;
    step();
    chk("armed_to_set", 3'd1, 16'h0630, 0, 0, 0);
    set_mode = 1'b0;
    step();
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rearmed", 3'd2, 16'h0630, 1, 0, 0);

    start_ring();
    tick(); tick();
    chk("ring3_two_ticks", 3'd3, 16'h0630, 1, 1, 0);
`ifdef ALARM_SNOOZE_EN
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("snooze_enter", 3'd4, 16'h0630, 1, 0, 0);
    tick(); tick();
    chk("snooze_hold", 3'd4, 16'h0630, 1, 0, 0);
    tick();
    chk("snooze_resume", 3'd3, 16'h0630, 1, 1, 0);
    // Fresh ring period: 59 ticks still ringing, 60th stops
    for (int k = 1; k < 60; k++) tick();
    chk("resume_cnt_cleared", 3'd3, 16'h0630, 1, 1, 1);
    tick();
    chk("resume_timeout", 3'd2, 16'h0630, 1, 0, 0);
    start_ring();
    tick();
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("snooze_again", 3'd4, 16'h0630, 1, 0, 0);
`else
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("snooze_ignored", 3'd3, 16'h0630, 1, 1, 0);
    tick();
    chk("ring_after_snooze_btn", 3'd3, 16'h0630, 1, 1, 1);
`endif

    // Reset mid-cycle loses the alarm time
    reset = 1'b1;
    step();
    chk("reset_mid_alarm", 3'd0, 16'h0000, 0, 0, 0);
    reset = 1'b0;
    step();
    chk("idle_after_reset2", 3'd0, 16'h0000, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
